// File: rtl/iob_uart2iob_if.sv
// ---------------------------------------------------------------------------
// iob_uart2iob_if
//   IOb native bus bundle between the UART bridge (master) and the SoC
//   interconnect (slave).
//
//   iob_avalid_o  master->slave  request valid
//   iob_addr_o    master->slave  request address (ADDR_W bits)
//   iob_wdata_o   master->slave  write data
//   iob_wstrb_o   master->slave  byte write strobes, 0 = read
//   iob_ready_i   slave->master  request accepted this cycle
//   iob_rvalid_i  slave->master  read data valid
//   iob_rdata_i   slave->master  read data
//   Signal suffixes are from the bridge's point of view.
// ---------------------------------------------------------------------------
interface iob_uart2iob_if #(
  parameter int ADDR_W = 32
) ();
  logic              iob_avalid_o;
  logic [ADDR_W-1:0] iob_addr_o;
  logic [31:0]       iob_wdata_o;
  logic [3:0]        iob_wstrb_o;
  logic              iob_ready_i;
  logic              iob_rvalid_i;
  logic [31:0]       iob_rdata_i;

  modport master (
    output iob_avalid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o,
    input  iob_ready_i, iob_rvalid_i, iob_rdata_i
  );

  modport slave (
    input  iob_avalid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o,
    output iob_ready_i, iob_rvalid_i, iob_rdata_i
  );
endinterface

// File: rtl/iob_uart2iob.sv
// ---------------------------------------------------------------------------
// iob_uart2iob
//   Debug/boot bridge: receives 8N1 command frames on rxd_i and replays them
//   as IOb bus transactions. Writes are acknowledged with byte 0x06, reads
//   return the 32-bit read word LSB byte first on txd_o.
//
//   Frame: cmd (opcode in [1:0], 01=read 10=write; wstrb in [7:4]),
//          4 address bytes LE, then 4 data bytes LE for writes.
//
//   clk_i, arst_n_i  clock, asynchronous active-low reset
//   cke_i            clock enable, 0 freezes every flop
//   rxd_i / txd_o    serial in / out, idle high
//   cts_i            peer ready, gates the start of each TX byte
//   rts_o            bridge accepts frame bytes (IDLE/ADDR/WDATA)
//   err_o            one-cycle pulse: framing error, bad opcode or timeout
//   iob              IOb master port
// ---------------------------------------------------------------------------
module iob_uart2iob #(
  parameter int BIT_DURATION = 868,
  parameter int TIMEOUT      = 100000,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32
) (
  input  logic               clk_i,
  input  logic               arst_n_i,
  input  logic               cke_i,
  input  logic               rxd_i,
  output logic               txd_o,
  input  logic               cts_i,
  output logic               rts_o,
  output logic               err_o,
  iob_uart2iob_if.master     iob
);

  localparam int CNT_W = $clog2(BIT_DURATION);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_DURATION - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_DURATION / 2 - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_WDATA, ST_REQ, ST_RWAIT, ST_RESP
  } state_e;

  // -------------------------------------------------------------------------
  // RX path
  // -------------------------------------------------------------------------
  logic             rxd_meta_q, rxd_sync_q, rxd_prev_q;
  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_ferr_q, rx_ferr_d;

  always_comb begin
    // NOTE: every _d gets a default first, so no branch can infer a latch.
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (rxd_prev_q && !rxd_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        // Recheck at half a bit: a glitch that is already high again is
        // dropped without any error.
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rxd_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_state_d = RX_IDLE;
          rx_valid_d = rxd_sync_q;
          rx_ferr_d  = !rxd_sync_q;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else if (cke_i) begin
      // NOTE: non-blocking assignments, so every flop samples pre-edge values.
      rxd_meta_q <= rxd_i;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  // -------------------------------------------------------------------------
  // Frame / bus FSM
  // -------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic              is_write_q, is_write_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [31:0]       resp_q, resp_d;
  logic [2:0]        resp_cnt_q, resp_cnt_d;
  logic              err_q, err_d;
  logic              rts_q, rts_d;
  logic              iob_avalid;

  tx_state_e         tx_state_q, tx_state_d;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic [2:0]        tx_bit_q, tx_bit_d;
  logic [7:0]        tx_shift_q, tx_shift_d;
  logic              tx_ready, tx_load;

  // TX can take a new byte when idle or in the last cycle of a stop bit,
  // which gives back-to-back bytes without a gap.
  assign tx_ready = (tx_state_q == TX_IDLE) ||
                    ((tx_state_q == TX_STOP) && (tx_cnt_q == BIT_LAST));
  assign tx_load  = (state_q == ST_RESP) && (resp_cnt_q != 3'd0) &&
                    cts_i && tx_ready;

  // Next-state and datapath
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    is_write_d = is_write_q;
    wstrb_d    = wstrb_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    to_cnt_d   = to_cnt_q;
    resp_d     = resp_q;
    resp_cnt_d = resp_cnt_q;
    err_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rx_ferr_q) begin
          err_d = 1'b1;
        end else if (rx_valid_q) begin
          if (rx_shift_q[1:0] == 2'b01 || rx_shift_q[1:0] == 2'b10) begin
            state_d    = ST_ADDR;
            byte_cnt_d = '0;
            to_cnt_d   = '0;
            is_write_d = (rx_shift_q[1:0] == 2'b10);
            wstrb_d    = (rx_shift_q[1:0] == 2'b10) ? rx_shift_q[7:4] : 4'h0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_ADDR, ST_WDATA: begin
        if (rx_ferr_q) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (rx_valid_q) begin
          // Little-endian: shifting each new byte in from the top leaves
          // byte 0 in the low lane after four bytes.
          if (state_q == ST_ADDR) addr_d  = {rx_shift_q, addr_q[31:8]};
          else                    wdata_d = {rx_shift_q, wdata_q[DATA_W-1:8]};
          to_cnt_d   = '0;
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == 2'd3) begin
            if (state_q == ST_ADDR && is_write_q) state_d = ST_WDATA;
            else                                  state_d = ST_REQ;
          end
        end else if (to_cnt_q == TO_LAST) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      ST_REQ: begin
        if (iob.iob_ready_i) begin
          if (is_write_q) begin
            state_d    = ST_RESP;
            resp_d     = 32'h0000_0006;
            resp_cnt_d = 3'd1;
          end else begin
            state_d = ST_RWAIT;
          end
        end
      end
      ST_RWAIT: begin
        if (iob.iob_rvalid_i) begin
          state_d    = ST_RESP;
          resp_d     = iob.iob_rdata_i;
          resp_cnt_d = 3'd4;
        end
      end
      ST_RESP: begin
        if (tx_load) begin
          resp_d     = {8'h00, resp_q[31:8]};
          resp_cnt_d = resp_cnt_q - 1'b1;
        end else if (resp_cnt_q == 3'd0 && tx_state_q == TX_IDLE) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    iob_avalid = (state_q == ST_REQ);
    rts_d      = (state_d == ST_IDLE) || (state_d == ST_ADDR) ||
                 (state_d == ST_WDATA);
  end

  // State register
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      is_write_q <= 1'b0;
      wstrb_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      to_cnt_q   <= '0;
      resp_q     <= '0;
      resp_cnt_q <= '0;
      err_q      <= 1'b0;
      rts_q      <= 1'b0;
    end else if (cke_i) begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      is_write_q <= is_write_d;
      wstrb_q    <= wstrb_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      to_cnt_q   <= to_cnt_d;
      resp_q     <= resp_d;
      resp_cnt_q <= resp_cnt_d;
      err_q      <= err_d;
      rts_q      <= rts_d;
    end
  end

  // -------------------------------------------------------------------------
  // TX path
  // -------------------------------------------------------------------------
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (tx_load) begin
          tx_state_d = TX_START;
          tx_cnt_d   = '0;
          tx_shift_d = resp_q[7:0];
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 1'b1;
          if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_load) begin
            tx_state_d = TX_START;
            tx_shift_d = resp_q[7:0];
          end else begin
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
    end else if (cke_i) begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  // -------------------------------------------------------------------------
  // Port drive
  // -------------------------------------------------------------------------
  assign txd_o = (tx_state_q == TX_START) ? 1'b0 :
                 (tx_state_q == TX_DATA)  ? tx_shift_q[0] : 1'b1;
  assign rts_o = rts_q;
  assign err_o = err_q;

  assign iob.iob_avalid_o = iob_avalid;
  assign iob.iob_addr_o   = addr_q[ADDR_W-1:0];
  assign iob.iob_wdata_o  = wdata_q;
  assign iob.iob_wstrb_o  = wstrb_q;

endmodule

// File: tb/tb_iob_uart2iob.sv
// ---------------------------------------------------------------------------
// tb_iob_uart2iob
//   Directed and randomized frames against a byte-level serial model, an IOb
//   memory model acting as slave, and a serial decoder for the responses.
// ---------------------------------------------------------------------------
module tb_iob_uart2iob;
  localparam int BIT = 4;
  localparam int TO  = 50;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic cke = 1'b0;
  logic rxd = 1'b1;
  logic cts = 1'b1;
  logic txd, rts, err;

  iob_uart2iob_if #(.ADDR_W(32)) bus ();

  iob_uart2iob #(
    .BIT_DURATION(BIT), .TIMEOUT(TO), .ADDR_W(32), .DATA_W(32)
  ) dut (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .rxd_i(rxd),
    .txd_o(txd), .cts_i(cts), .rts_o(rts), .err_o(err), .iob(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int err_cnt = 0;
  int req_cnt = 0;
  logic av_prev = 1'b0;
  logic [7:0]  frame_q[$];
  logic [31:0] mem [logic [31:0]];

  always @(posedge clk) cyc <= cyc + 1;

  // Cycles with err_o high and rising edges of iob_avalid_o.
  always @(negedge clk) begin
    if (err === 1'b1) err_cnt <= err_cnt + 1;
    if (bus.iob_avalid_o === 1'b1 && av_prev !== 1'b1) req_cnt <= req_cnt + 1;
    av_prev <= bus.iob_avalid_o;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] frm;
    frm = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = frm[i];
      repeat (BIT) @(negedge clk);
    end
    rxd = 1'b1;
  endtask

  task automatic send_frame();
    foreach (frame_q[i]) send_byte(frame_q[i], 1'b1);
  endtask

  // Decode one 8N1 byte from txd; sc is the cycle the start bit was seen.
  task automatic recv_byte(output logic [7:0] b, output int sc,
                           input bit drop_cts);
    int n = 0;
    b = 8'h00;
    while (txd !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    sc = cyc;
    if (txd !== 1'b0) begin
      check("tx_start_seen", {31'd0, txd}, 32'd0);
      return;
    end
    if (drop_cts) cts = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (i == 0 ? BIT + BIT / 2 : BIT) @(negedge clk);
      b[i] = txd;
    end
    repeat (BIT) @(negedge clk);
    check("tx_stop_bit", {31'd0, txd}, 32'd1);
    cts = 1'b1;
  endtask

  // IOb slave side of one request; base is the cycle the FSM leaves
  // REQ (write) or RWAIT (read).
  task automatic bus_phase(input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] strb,
                           input int rdy_d, input int rv_d, output int base);
    int n = 0;
    int dur = 0;
    logic stable = 1'b1;
    base = cyc;
    while (bus.iob_avalid_o !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("avalid_rise", {31'd0, bus.iob_avalid_o}, 32'd1);
    if (bus.iob_avalid_o !== 1'b1) return;
    check("req_addr", bus.iob_addr_o, addr);
    check("req_wstrb", {28'd0, bus.iob_wstrb_o}, {28'd0, wr ? strb : 4'h0});
    if (wr) check("req_wdata", bus.iob_wdata_o, data);
    check("rts_in_req", {31'd0, rts}, 32'd0);
    while (bus.iob_avalid_o === 1'b1 && dur < 64) begin
      dur++;
      stable = stable && (bus.iob_addr_o === addr) &&
               (bus.iob_wstrb_o === (wr ? strb : 4'h0));
      // rvalid during REQ must be ignored
      if (!wr && dur == 1 && rdy_d > 0) begin
        bus.iob_rvalid_i = 1'b1;
        bus.iob_rdata_i  = 32'hBAD0_0BAD;
      end else begin
        bus.iob_rvalid_i = 1'b0;
      end
      if (dur >= rdy_d + 1) bus.iob_ready_i = 1'b1;
      base = cyc;
      @(negedge clk);
    end
    bus.iob_ready_i  = 1'b0;
    bus.iob_rvalid_i = 1'b0;
    check("avalid_len", dur, rdy_d + 1);
    check("req_stable", {31'd0, stable}, 32'd1);
    if (!wr) begin
      repeat (rv_d - 1) @(negedge clk);
      bus.iob_rvalid_i = 1'b1;
      bus.iob_rdata_i  = data;
      base = cyc;
      @(negedge clk);
      bus.iob_rvalid_i = 1'b0;
      bus.iob_rdata_i  = $urandom;
    end
  endtask

  // One full transaction: frame out, bus phase, response decode.
  task automatic do_txn(input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb,
                        input int rdy_d, input int rv_d, input int cts_hold);
    logic [7:0]  cmd;
    logic [31:0] rd;
    logic [31:0] cur;
    logic [7:0]  exp_q[$];
    logic [7:0]  b;
    int base, sc, prev;
    logic [3:0] junk;
    junk = 4'($urandom);
    cmd = {wr ? strb : junk, 2'($urandom), wr ? 2'b10 : 2'b01};
    frame_q.delete();
    frame_q.push_back(cmd);
    for (int i = 0; i < 4; i++) frame_q.push_back(addr[8*i +: 8]);
    if (wr) for (int i = 0; i < 4; i++) frame_q.push_back(data[8*i +: 8]);
    if (cts_hold > 0) cts = 1'b0;
    send_frame();
    if (wr) begin
      cur = mem.exists(addr) ? mem[addr] : 32'h0;
      for (int i = 0; i < 4; i++) if (strb[i]) cur[8*i +: 8] = data[8*i +: 8];
      mem[addr] = cur;
      exp_q.push_back(8'h06);
      rd = data;
    end else begin
      rd = mem.exists(addr) ? mem[addr] : $urandom;
      mem[addr] = rd;
      for (int i = 0; i < 4; i++) exp_q.push_back(rd[8*i +: 8]);
    end
    bus_phase(wr, addr, rd, strb, rdy_d, rv_d, base);
    if (cts_hold > 0) begin
      logic quiet = 1'b1;
      for (int i = 0; i < cts_hold; i++) begin
        @(negedge clk);
        quiet = quiet && (txd === 1'b1);
      end
      check("txd_idle_while_cts_low", {31'd0, quiet}, 32'd1);
      cts = 1'b1;
    end
    prev = 0;
    foreach (exp_q[i]) begin
      recv_byte(b, sc, cts_hold > 0 && i == 0);
      check("resp_byte", {24'd0, b}, {24'd0, exp_q[i]});
      if (i == 0 && cts_hold == 0) check("resp_start", sc, base + 2);
      if (i > 0) check("resp_gap", sc - prev, 10 * BIT);
      prev = sc;
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int e0, r0, n;
    bus.iob_ready_i  = 1'b0;
    bus.iob_rvalid_i = 1'b0;
    bus.iob_rdata_i  = 32'h0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_rts", {31'd0, rts}, 32'd0);
    check("rst_avalid", {31'd0, bus.iob_avalid_o}, 32'd0);
    check("rst_addr", bus.iob_addr_o, 32'd0);
    check("rst_wdata", bus.iob_wdata_o, 32'd0);
    check("rst_wstrb", {28'd0, bus.iob_wstrb_o}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);

    // Release with cke low: rts must wait for the first enabled cycle.
    arst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rts_frozen_cke0", {31'd0, rts}, 32'd0);
    cke = 1'b1;
    @(negedge clk);
    check("rts_first_enabled", {31'd0, rts}, 32'd1);
    repeat (4) @(negedge clk);

    // Write, ready already high
    do_txn(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 1, 0);
    // Read, ready after 3 cycles, rvalid 2 cycles later
    mem[32'h0000_0004] = 32'h1234_5678;
    do_txn(1'b0, 32'h0000_0004, 32'h0, 4'h0, 3, 2, 0);

    // Bad opcode
    e0 = err_cnt; r0 = req_cnt;
    send_byte(8'h03, 1'b1);
    repeat (10) @(negedge clk);
    check("badop_err", err_cnt - e0, 1);
    check("badop_no_req", req_cnt - r0, 0);
    do_txn(1'b0, 32'h8000_0010, 32'h0, 4'h0, 1, 1, 0);

    // Framing error on a command byte
    e0 = err_cnt; r0 = req_cnt;
    send_byte(8'h01, 1'b0);
    repeat (10) @(negedge clk);
    check("ferr_err", err_cnt - e0, 1);
    check("ferr_no_req", req_cnt - r0, 0);
    check("ferr_rts", {31'd0, rts}, 32'd1);
    do_txn(1'b1, 32'h0000_0008, 32'hCAFE_F00D, 4'h5, 2, 1, 0);

    // Timeout after a partial frame
    e0 = err_cnt; r0 = req_cnt;
    send_byte(8'h01, 1'b1);
    send_byte(8'h44, 1'b1);
    send_byte(8'h33, 1'b1);
    repeat (40) @(negedge clk);
    check("timeout_not_early", err_cnt - e0, 0);
    repeat (20) @(negedge clk);
    check("timeout_err", err_cnt - e0, 1);
    check("timeout_no_req", req_cnt - r0, 0);
    do_txn(1'b0, 32'h0000_0008, 32'h0, 4'h0, 0, 3, 0);

    // Flow control: cts low through RESP, then dropped mid-byte
    do_txn(1'b0, 32'h8000_0010, 32'h0, 4'h0, 1, 1, 100);
    do_txn(1'b1, 32'h0000_000C, 32'h0102_0304, 4'hC, 0, 1, 60);

    // Reset during REQ
    frame_q.delete();
    frame_q.push_back(8'hF2);
    for (int i = 0; i < 8; i++) frame_q.push_back(8'(i + 1));
    send_frame();
    n = 0;
    while (bus.iob_avalid_o !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rstreq_avalid_rise", {31'd0, bus.iob_avalid_o}, 32'd1);
    arst_n = 1'b0;
    #1;
    check("rstreq_avalid", {31'd0, bus.iob_avalid_o}, 32'd0);
    check("rstreq_txd", {31'd0, txd}, 32'd1);
    check("rstreq_addr", bus.iob_addr_o, 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    r0 = req_cnt;
    repeat (60) @(negedge clk);
    check("rstreq_no_reissue", req_cnt - r0, 0);
    check("rstreq_rts", {31'd0, rts}, 32'd1);

    // Randomized transactions against the memory model
    for (int k = 0; k < 8; k++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 1) ? 32'hA5A5_0000 : 32'h0000_1000) |
          32'($urandom_range(0, 3) << 2);
      do_txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(1, 15)),
             $urandom_range(0, 4), $urandom_range(1, 4), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/iob_uart2iob.md
# iob_uart2iob

UART-to-IOb bridge: a debug/boot initiator that receives command frames over a 8N1 serial line and replays them as IOb native bus transactions. It sits on the far side of the serial link from the SoC's UART peripheral and drives the SoC bus as a master. It returns an acknowledge byte for writes and the read word for reads.

## Interface
- BIT_DURATION, 868: clock cycles per UART bit; minimum 4.
- TIMEOUT, 100000: idle cycles allowed between bytes of one frame.
- ADDR_W, 32: IOb address width; must be ≤32.
- DATA_W, 32: IOb data width; fixed at 32.
- clk_i  in  1  system clock.
- arst_n_i  in  1  asynchronous active-low reset.
- cke_i  in  1  clock enable; when 0, all state holds.
- rxd_i  in  1  serial input; idle high.
- txd_o  out  1  serial output; idle high.
- cts_i  in  1  peer ready; a TX byte starts only while this is 1.
- rts_o  out  1  bridge ready to accept frame bytes.
- iob_avalid_o  out  1  request valid.
- iob_addr_o  out  ADDR_W  address.
- iob_wdata_o  out  32  write data.
- iob_wstrb_o  out  4  write strobe; 0 means read.
- iob_ready_i  in  1  request accepted this cycle.
- iob_rvalid_i  in  1  read data valid.
- iob_rdata_i  in  32  read data.
- err_o  out  1  one-cycle pulse on framing error, bad command or timeout.

## Operation
- Frame layout:
  - Byte 0 is the command. cmd[1:0] is the opcode: 2'b01 = read, 2'b10 = write. cmd[7:4] is wstrb, used for writes only.
  - Next come 4 address bytes, little-endian. Bits above ADDR_W are dropped.
  - Writes then carry 4 data bytes, little-endian.
- RX path:
  - rxd_i passes through a 2-flop synchronizer.
  - A falling edge in RX-idle starts a byte. The start bit is rechecked at BIT_DURATION/2; if high, it is discarded silently.
  - Data bits are sampled at mid-bit, LSB first. The stop bit is sampled at mid-bit.
  - Stop bit = 0: byte discarded, err_o pulses, FSM returns to IDLE.
- FSM states:
  - IDLE: valid opcode -> ADDR with byte counter 0. Invalid opcode -> err_o pulse, stay IDLE.
  - ADDR: after 4 bytes, read -> REQ; write -> WDATA.
  - WDATA: after 4 bytes -> REQ.
  - REQ: iob_avalid_o=1, address/data/strobe held stable. When iob_ready_i=1, write -> RESP with 1 byte (0x06); read -> RWAIT.
  - RWAIT: on iob_rvalid_i=1, capture iob_rdata_i -> RESP with 4 bytes (LSB byte first).
  - RESP: transmit the queued bytes, then -> IDLE.
- Timeout: in ADDR/WDATA, a cycle counter restarts on each completed byte. When it reaches TIMEOUT -> IDLE, err_o pulse, partial frame dropped.
- rts_o = 1 only in IDLE/ADDR/WDATA. Bytes arriving in REQ/RWAIT/RESP are received and discarded without error.
- TX path:
  - 8N1, LSB first. Start bit low and stop bit high, each BIT_DURATION cycles.
  - Between bytes, waits for cts_i=1 before the start bit. cts_i dropping mid-byte does not abort that byte.

## Timing
- Reset values: txd_o=1, rts_o=0, iob_avalid_o=0, iob_addr_o=0, iob_wdata_o=0, iob_wstrb_o=0, err_o=0. FSM=IDLE, RX and TX idle.
- rts_o is registered; it rises on the first enabled cycle after reset release.
- A byte completes in the cycle after its stop-bit sample. The FSM consumes it the same cycle.
- iob_avalid_o rises 1 cycle after the last frame byte completes.
- Request handshake:
  - iob_avalid_o falls in the cycle after iob_ready_i=1.
  - If iob_ready_i is already 1 when iob_avalid_o is asserted, the request lasts exactly 1 cycle.
- iob_rvalid_i is honoured only in RWAIT; it is ignored in all other states.
- TX start bit begins 1 cycle after entry to RESP, if cts_i=1.
- Back-to-back TX bytes have no gap while cts_i=1. A response byte lasts 10·BIT_DURATION cycles.
- Reset asserted mid-frame or mid-transaction aborts immediately to reset values. No bus request is re-issued.
- cke_i=0 freezes all counters, including baud and timeout.

## Test plan
- Write: send 0xF2, 0x10,0x00,0x00,0x80, 0xEF,0xBE,0xAD,0xDE with ready held 1 -> one-cycle avalid with addr=0x80000010, wdata=0xDEADBEEF, wstrb=0xF; then txd_o sends 0x06.
- Read: send 0x01, 0x04,0,0,0; drive ready after 3 cycles and rvalid=1, rdata=0x12345678 two cycles later -> avalid held 4 cycles with wstrb=0; txd_o sends 0x78,0x56,0x34,0x12.
- Bad opcode: send 0x03 -> err_o pulses once, no bus activity; a valid frame sent next completes normally.
- Framing error: send a command byte with its stop bit forced 0 -> err_o pulse, FSM in IDLE, no avalid.
- Timeout (TIMEOUT=50): send 0x01 and 2 address bytes, then idle 60 cycles -> err_o pulse at count 50; a full frame sent afterwards succeeds.
- Flow control and reset: hold cts_i=0 during RESP -> txd_o stays 1 until cts_i=1. Assert arst_n_i=0 during REQ -> avalid=0 and txd_o=1 immediately.
